// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives one data-memory access per instruction.
// Stores are placed on byte lanes. Loads return the selected lane, zero- or
// sign-extended. The stage flags misaligned or illegal requests, and gives up
// on a bus that never signals ready.
module mem_access_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        ivalid,
    input  logic        imem_read,
    input  logic        imem_write,
    input  logic [1:0]  iwidth,
    input  logic        isigned,
    input  logic [31:0] ialu_res,
    input  logic [31:0] istore_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic [31:0] oData_mem_res,
    output logic        odone,
    output logic        ostall,
    output logic [1:0]  oerr
);
    typedef enum logic {IDLE, BUSY} state_t;

    // The last BUSY cycle without ready is the one where the count reaches 255.
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;

    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_off;
    logic [1:0]  r_width;
    logic        r_signed;
    logic        r_req, r_we, r_done;
    logic [31:0] r_addr, r_wdata, r_res;
    logic [3:0]  r_be;
    logic [1:0]  r_err;

    logic        w_idle, w_one_op, w_aligned, w_start, w_legal, w_bad;
    logic        w_complete, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;

    assign w_idle     = (r_state == IDLE);
    assign w_one_op   = imem_read ^ imem_write;
    assign w_aligned  = (iwidth == 2'b00)
                      | ((iwidth == 2'b01) & ~ialu_res[0])
                      | ((iwidth == 2'b10) & (ialu_res[1:0] == 2'b00));
    assign w_start    = w_idle & ivalid & w_one_op;
    assign w_legal    = w_start & w_aligned;
    // Misaligned, width 11, or read+write together are all rejected in one cycle.
    assign w_bad      = w_idle & ivalid & ((w_one_op & ~w_aligned) | (imem_read & imem_write));
    assign w_complete = (r_state == BUSY) & dmem_ready;
    assign w_timeout  = (r_state == BUSY) & ~dmem_ready & (r_cnt == TIMEOUT_LAST);

    // Stall covers the start cycle too, so upstream holds until the access ends.
    assign ostall = ~reset & (w_legal | (r_state == BUSY));

    // Store lane placement from the incoming byte address.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = istore_data;
        case (iwidth)
            2'b00: begin
                w_be    = 4'b0001 << ialu_res[1:0];
                w_wdata = {4{istore_data[7:0]}};
            end
            2'b01: begin
                w_be    = ialu_res[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{istore_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane extraction uses the captured offset and width.
    always_comb begin
        w_lane_b = dmem_rdata[{r_off, 3'b000} +: 8];
        w_lane_h = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_width)
            2'b00:   w_load = {{24{r_signed & w_lane_b[7]}}, w_lane_b};
            2'b01:   w_load = {{16{r_signed & w_lane_h[15]}}, w_lane_h};
            default: w_load = dmem_rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state: a legal start enters BUSY; ready or timeout returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_legal) w_next = BUSY;
            BUSY: if (w_complete | w_timeout) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Registered bus outputs, result, pulses and timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= 4'b0000;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_res    <= 32'd0;
            r_done   <= 1'b0;
            r_err    <= 2'b00;
            r_cnt    <= 8'd0;
            r_off    <= 2'b00;
            r_width  <= 2'b00;
            r_signed <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 2'b00;
            if (w_legal) begin
                r_req    <= 1'b1;
                r_we     <= imem_write;
                r_be     <= w_be;
                r_addr   <= {ialu_res[31:2], 2'b00};
                r_wdata  <= w_wdata;
                r_off    <= ialu_res[1:0];
                r_width  <= iwidth;
                r_signed <= isigned;
                r_cnt    <= 8'd0;
            end else if (w_bad) begin
                r_done <= 1'b1;
                r_err  <= 2'b01;
            end else if (w_complete) begin
                r_req  <= 1'b0;
                r_done <= 1'b1;
                if (!r_we) r_res <= w_load;
            end else if (w_timeout) begin
                r_req  <= 1'b0;
                r_done <= 1'b1;
                r_err  <= 2'b10;
                r_cnt  <= r_cnt + 8'd1;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_be       = r_be;
    assign dmem_addr     = r_addr;
    assign dmem_wdata    = r_wdata;
    assign oData_mem_res = r_res;
    assign odone         = r_done;
    assign oerr          = r_err;
endmodule
